imm_encoder_pipe: RTL and testbench

// - Inverse of the immediate extractor: packs a 32-bit signed/unsigned immediate plus register/opcode fields into a RISC-V instruction word.
// - Handles I/S/B/U/J formats, range-checks the immediate and flags overflow.
// - Two-stage valid/ready pipeline. Feeds the instruction-memory loader and self-test generator; counts encodes and errors.

---
 rtl/imm_encoder_pipe.sv | 178 +++++++++++++++++
 tb/tb_imm_encoder_pipe.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder_pipe.sv
// Packs an immediate plus register/opcode fields into an RV32 I/S/B/U/J word, range-checks the immediate, counts deliveries and errors.
// Latency: two register stages (S1 request/range check, S2 word/flags); a request sampled at one edge is presented after the next edge.
// Backpressure: valid/ready; each stage advances when the next is empty or draining, so in_ready depends combinationally on out_ready.
//
// Ports: clk, rst_n (async active-low); in_valid/in_ready request handshake with in_sel_ext (000 I, 001 S,
// 010 B, 011 U, 100 J), in_imm, in_opcode, in_rd, in_rs1, in_rs2, in_funct3; out_valid/out_ready result handshake
// with out_instr, out_err, out_rt_mismatch; clr_cnt clears the saturating enc_count/err_count statistics.
// Optional feature macro: ENC_ROUNDTRIP_CHECK_EN (re-extracts the immediate from the encoded word in S2).
module imm_encoder_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_sel_ext,
    input  logic [31:0]      in_imm,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic             out_rt_mismatch,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);
    localparam logic [2:0] SEL_I = 3'd0;
    localparam logic [2:0] SEL_S = 3'd1;
    localparam logic [2:0] SEL_B = 3'd2;
    localparam logic [2:0] SEL_U = 3'd3;
    localparam logic [2:0] SEL_J = 3'd4;

    logic        s1_valid;
    logic [2:0]  s1_sel;
    logic [31:0] s1_imm;
    logic [6:0]  s1_op;
    logic [4:0]  s1_rd;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic [2:0]  s1_f3;
    logic        s1_err;

    logic        s2_ready;
    logic        in_err;
    logic [31:0] asm_instr;
    logic        deliver;

    // out_valid is the S2 valid bit.
    assign s2_ready = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_ready;
    assign deliver  = out_valid && out_ready;

    // Signed range check: upper bits must be a pure sign extension; B/J also need an even offset.
    // An invalid format is folded into the same error flag.
    always_comb begin
        in_err = 1'b0;
        case (in_sel_ext)
            SEL_I, SEL_S: in_err = !((&in_imm[31:11]) || !(|in_imm[31:11]));
            SEL_B:        in_err = in_imm[0] || !((&in_imm[31:12]) || !(|in_imm[31:12]));
            SEL_J:        in_err = in_imm[0] || !((&in_imm[31:20]) || !(|in_imm[31:20]));
            SEL_U:        in_err = |in_imm[11:0];
            default:      in_err = 1'b1;
        endcase
    end

    // Out-of-range immediates still produce the truncated word; invalid formats produce zero.
    always_comb begin
        asm_instr = '0;
        case (s1_sel)
            SEL_I: asm_instr = {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, s1_op};
            SEL_S: asm_instr = {s1_imm[11:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:0], s1_op};
            SEL_B: asm_instr = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_f3,
                                s1_imm[4:1], s1_imm[11], s1_op};
            SEL_U: asm_instr = {s1_imm[31:12], s1_rd, s1_op};
            SEL_J: asm_instr = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, s1_op};
            default: asm_instr = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sel   <= '0;
            s1_imm   <= '0;
            s1_op    <= '0;
            s1_rd    <= '0;
            s1_rs1   <= '0;
            s1_rs2   <= '0;
            s1_f3    <= '0;
            s1_err   <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sel <= in_sel_ext;
                s1_imm <= in_imm;
                s1_op  <= in_opcode;
                s1_rd  <= in_rd;
                s1_rs1 <= in_rs1;
                s1_rs2 <= in_rs2;
                s1_f3  <= in_funct3;
                s1_err <= in_err;
            end
        end
    end

    // Data only loads with a valid item so a stalled result stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_err   <= 1'b0;
        end else if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_instr <= asm_instr;
                out_err   <= s1_err;
            end
        end
    end

`ifdef ENC_ROUNDTRIP_CHECK_EN
    logic [31:0] rt_imm;
    logic        asm_rt;

    // Decode the word back exactly as the extractor would; any difference means the slices lost information.
    always_comb begin
        rt_imm = '0;
        asm_rt = 1'b0;
        case (s1_sel)
            SEL_I: rt_imm = {{20{asm_instr[31]}}, asm_instr[31:20]};
            SEL_S: rt_imm = {{20{asm_instr[31]}}, asm_instr[31:25], asm_instr[11:7]};
            SEL_B: rt_imm = {{19{asm_instr[31]}}, asm_instr[31], asm_instr[7],
                             asm_instr[30:25], asm_instr[11:8], 1'b0};
            SEL_U: rt_imm = {asm_instr[31:12], 12'h000};
            SEL_J: rt_imm = {{11{asm_instr[31]}}, asm_instr[31], asm_instr[19:12],
                             asm_instr[20], asm_instr[30:21], 1'b0};
            default: rt_imm = '0;
        endcase
        if (s1_sel <= SEL_J) begin
            asm_rt = (rt_imm != s1_imm);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_rt_mismatch <= 1'b0;
        end else if (s2_ready && s1_valid) begin
            out_rt_mismatch <= asm_rt;
        end
    end
`else
    assign out_rt_mismatch = 1'b0;
`endif

    // Saturating statistics; a clear in the same cycle as a delivery wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_count <= '0;
            err_count <= '0;
        end else if (clr_cnt) begin
            enc_count <= '0;
            err_count <= '0;
        end else if (deliver) begin
            if (enc_count != '1) begin
                enc_count <= enc_count + CNT_W'(1);
            end
            if (out_err && (err_count != '1)) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_imm_encoder_pipe.sv
// Bench for imm_encoder_pipe: directed encodings, backpressure, mid-flight reset and randomized traffic.
// Expected results come from a format-rule model and a queue scoreboard; counters tracked in the bench.
// Narrow counters (4 bits) so saturation is reached within the random phase.
module tb_imm_encoder_pipe;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [2:0]  sel;
        logic [31:0] imm;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
    } req_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
        logic        rt;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_sel_ext;
    logic [31:0]      in_imm;
    logic [6:0]       in_opcode;
    logic [4:0]       in_rd;
    logic [4:0]       in_rs1;
    logic [4:0]       in_rs2;
    logic [2:0]       in_funct3;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic             out_err;
    logic             out_rt_mismatch;
    logic             clr_cnt;
    logic [CNT_W-1:0] enc_count;
    logic [CNT_W-1:0] err_count;

    imm_encoder_pipe #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_sel_ext     (in_sel_ext),
        .in_imm         (in_imm),
        .in_opcode      (in_opcode),
        .in_rd          (in_rd),
        .in_rs1         (in_rs1),
        .in_rs2         (in_rs2),
        .in_funct3      (in_funct3),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_err        (out_err),
        .out_rt_mismatch(out_rt_mismatch),
        .clr_cnt        (clr_cnt),
        .enc_count      (enc_count),
        .err_count      (err_count)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_acc   = 0;
    int   enc_exp = 0;
    int   err_exp = 0;
    logic rand_rdy = 1'b0;
    logic rand_gap = 1'b0;
    logic rand_clr = 1'b0;
    req_t pend[$];
    exp_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_rt(input logic [2:0] sel, input logic err);
`ifdef ENC_ROUNDTRIP_CHECK_EN
        return (sel <= 3'd4) ? err : 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    // Range rules as numeric intervals; word layout as the format definitions.
    function automatic exp_t model(input req_t r);
        exp_t e;
        int   v;
        v       = int'($signed(r.imm));
        e.instr = 32'h0;
        e.err   = 1'b1;
        case (r.sel)
            3'd0: begin
                e.err   = (v < -2048) || (v > 2047);
                e.instr = {r.imm[11:0], r.rs1, r.f3, r.rd, r.op};
            end
            3'd1: begin
                e.err   = (v < -2048) || (v > 2047);
                e.instr = {r.imm[11:5], r.rs2, r.rs1, r.f3, r.imm[4:0], r.op};
            end
            3'd2: begin
                e.err   = ((v % 2) != 0) || (v < -4096) || (v > 4095);
                e.instr = {r.imm[12], r.imm[10:5], r.rs2, r.rs1, r.f3, r.imm[4:1], r.imm[11], r.op};
            end
            3'd3: begin
                e.err   = (r.imm % 32'd4096) != 32'd0;
                e.instr = {r.imm[31:12], r.rd, r.op};
            end
            3'd4: begin
                e.err   = ((v % 2) != 0) || (v < -1048576) || (v > 1048575);
                e.instr = {r.imm[20], r.imm[10:1], r.imm[11], r.imm[19:12], r.rd, r.op};
            end
            default: begin
                e.instr = 32'h0;
                e.err   = 1'b1;
            end
        endcase
        e.rt = exp_rt(r.sel, e.err);
        return e;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        int   x;
        r.sel = ($urandom_range(0, 9) > 7) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
        case ($urandom_range(0, 3))
            0: r.imm = $urandom;
            1: begin x = int'($urandom_range(0, 8191)) - 4096; r.imm = 32'(x); end
            2: begin x = int'($urandom_range(0, 2097151)) - 1048576; r.imm = 32'(x); end
            default: r.imm = $urandom & 32'hFFFFF000;
        endcase
        if ($urandom_range(0, 1) == 1) r.imm[0] = 1'b0;
        if ($urandom_range(0, 5) == 0) r.imm[3] = 1'b1;
        r.op  = 7'($urandom_range(0, 127));
        r.rd  = 5'($urandom_range(0, 31));
        r.rs1 = 5'($urandom_range(0, 31));
        r.rs2 = 5'($urandom_range(0, 31));
        r.f3  = 3'($urandom_range(0, 7));
        return r;
    endfunction

    task automatic drive(input logic acc);
        if (in_valid && !acc) begin
            // hold the unaccepted request stable
        end else if ((pend.size() > 0) && (!rand_gap || ($urandom_range(0, 2) != 0))) begin
            in_sel_ext = pend[0].sel;
            in_imm     = pend[0].imm;
            in_opcode  = pend[0].op;
            in_rd      = pend[0].rd;
            in_rs1     = pend[0].rs1;
            in_rs2     = pend[0].rs2;
            in_funct3  = pend[0].f3;
            in_valid   = 1'b1;
        end else begin
            in_valid = 1'b0;
        end
    endtask

    // One clock: observe handshakes at the falling edge, update the scoreboard, drive after the rising edge.
    task automatic tick();
        exp_t e;
        logic acc;
        logic del;
        logic del_err;
        @(negedge clk);
        acc     = in_valid && in_ready;
        del     = out_valid && out_ready;
        del_err = out_err;
        if (del) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", {31'b0, out_valid}, 32'h0);
            end else begin
                e = exp_q.pop_front();
                del_err = e.err;
                chk("instr", out_instr, e.instr);
                chk("err", {31'b0, out_err}, {31'b0, e.err});
                chk("rt_mismatch", {31'b0, out_rt_mismatch}, {31'b0, e.rt});
            end
        end
        if (clr_cnt) begin
            enc_exp = 0;
            err_exp = 0;
        end else if (del) begin
            if (enc_exp < CNT_MAX) enc_exp++;
            if (del_err && (err_exp < CNT_MAX)) err_exp++;
        end
        if (acc) begin
            exp_q.push_back(model(pend[0]));
            pend.delete(0);
            n_acc++;
        end
        @(posedge clk);
        #1;
        chk("enc_count", 32'(enc_count), 32'(enc_exp));
        chk("err_count", 32'(err_count), 32'(err_exp));
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        if (rand_clr) clr_cnt = ($urandom_range(0, 40) == 0);
        drive(acc);
    endtask

    task automatic run_one(input string tag, input logic [2:0] sel, input logic [31:0] imm,
                           input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [2:0] f3,
                           input logic [31:0] x_instr, input logic x_err);
        req_t r;
        int   a0;
        int   lat;
        int   guard;
        r = '{sel: sel, imm: imm, op: op, rd: rd, rs1: rs1, rs2: rs2, f3: f3};
        pend.push_back(r);
        out_ready = 1'b1;
        drive(1'b1);
        a0    = n_acc;
        guard = 0;
        while ((n_acc == a0) && (guard < 20)) begin
            tick();
            guard++;
        end
        chk({tag, "_accept"}, 32'(n_acc - a0), 32'd1);
        lat = 1;
        while (!out_valid && (lat < 20)) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd2);
        chk({tag, "_instr"}, out_instr, x_instr);
        chk({tag, "_err"}, {31'b0, out_err}, {31'b0, x_err});
        chk({tag, "_rt"}, {31'b0, out_rt_mismatch}, {31'b0, exp_rt(sel, x_err)});
        tick();
    endtask

    initial begin
        int acc0;
        int guard;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_sel_ext = '0;
        in_imm     = '0;
        in_opcode  = '0;
        in_rd      = '0;
        in_rs1     = '0;
        in_rs2     = '0;
        in_funct3  = '0;
        out_ready  = 1'b0;
        clr_cnt    = 1'b0;
        #23;
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_err", {31'b0, out_err}, 32'h0);
        chk("rst_rt", {31'b0, out_rt_mismatch}, 32'h0);
        chk("rst_enc_count", 32'(enc_count), 32'h0);
        chk("rst_err_count", 32'(err_count), 32'h0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_one("addi", 3'd0, 32'hFFFFFFFF, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFF00093, 1'b0);
        run_one("sw",   3'd1, 32'h00000008, 7'h23, 5'd0, 5'd3, 5'd2, 3'd2, 32'h0021A423, 1'b0);
        run_one("jal",  3'd4, 32'h00000800, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h001000EF, 1'b0);
        run_one("b_odd", 3'd2, 32'h00001001, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'h80000063, 1'b1);
        chk("b_odd_err_count", 32'(err_count), 32'd1);
        run_one("lui",  3'd3, 32'h12345000, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h123452B7, 1'b0);
        run_one("lui_bad", 3'd3, 32'h12345001, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h123452B7, 1'b1);
        run_one("i_ovf", 3'd0, 32'h00000800, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 32'h80010093, 1'b1);
        run_one("bad_sel", 3'd6, 32'h00000004, 7'h13, 5'd1, 5'd2, 5'd3, 3'd1, 32'h00000000, 1'b1);

        // Backpressure: three back-to-back requests against a stalled output.
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) pend.push_back(rand_req());
        drive(1'b1);
        acc0 = n_acc;
        for (int i = 0; i < 6; i++) tick();
        chk("bp_accepted", 32'(n_acc - acc0), 32'd2);
        chk("bp_in_ready", {31'b0, in_ready}, 32'h0);
        chk("bp_out_valid", {31'b0, out_valid}, 32'h1);
        out_ready = 1'b1;
        guard = 0;
        while (((pend.size() > 0) || (exp_q.size() > 0)) && (guard < 20)) begin
            tick();
            guard++;
        end
        chk("bp_drained", 32'(pend.size() + exp_q.size()), 32'd0);
        chk("bp_enc_count", 32'(enc_count), 32'd3);

        // Reset with both stages full drops everything immediately.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) pend.push_back(rand_req());
        drive(1'b1);
        for (int i = 0; i < 4; i++) tick();
        chk("pre_rst_out_valid", {31'b0, out_valid}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("midrst_enc_count", 32'(enc_count), 32'h0);
        chk("midrst_err_count", 32'(err_count), 32'h0);
        pend.delete();
        exp_q.delete();
        in_valid = 1'b0;
        enc_exp  = 0;
        err_exp  = 0;
        #7;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_one("post_rst", 3'd0, 32'hFFFFFFFF, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFF00093, 1'b0);

        // Randomized traffic with gaps, stalls and occasional clears.
        rand_rdy = 1'b1;
        rand_gap = 1'b1;
        rand_clr = 1'b1;
        for (int i = 0; i < 300; i++) pend.push_back(rand_req());
        drive(1'b1);
        guard = 0;
        while (((pend.size() > 0) || (exp_q.size() > 0)) && (guard < 5000)) begin
            tick();
            guard++;
        end
        chk("rand_drained", 32'(pend.size() + exp_q.size()), 32'd0);
        rand_rdy  = 1'b0;
        rand_gap  = 1'b0;
        rand_clr  = 1'b0;
        clr_cnt   = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
